// File: rtl/rr_mux4_pkg.sv
// Shared lane codes, output-register state type and grant-counter width for rr_mux4.
package rr_mux4_pkg;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    localparam int CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb4.sv
// Rotating-priority search over four requests: the first set bit at ptr, ptr+1, ptr+2, ptr+3 (mod 4) wins.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the closest requester to ptr is written last.
    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        cand    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
        gnt_onehot = any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

endmodule

// File: rtl/rr_mux4.sv
// Four-lane round-robin merge into one registered output word with valid/ready handshakes.
// Optional per-lane saturating grant counters are built when RR_MUX4_STATS_EN is defined.
module rr_mux4
    import rr_mux4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel
`ifdef RR_MUX4_STATS_EN
    ,
    output logic [4*CNT_W-1:0]  grant_cnt
`endif
);

    state_t              state;
    logic [1:0]          ptr;
    logic                load;
    logic                grant;
    logic [3:0]          gnt_onehot;
    logic [1:0]          gnt_idx;
    logic                any;
    logic [DATA_W-1:0]   win_data;

    rr_arb4 u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign load      = (state == EMPTY) || out_ready;
    assign grant     = load && any;
    // rst_n gates ready so no handshake is offered while reset is held.
    assign in_ready  = (load && rst_n) ? gnt_onehot : 4'b0000;
    assign out_valid = (state == FULL);

    always_comb begin
        win_data = in_data[0 +: DATA_W];
        for (int i = 0; i < 4; i++) begin
            if (gnt_idx == 2'(i)) begin
                win_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= LANE_A;
            ptr      <= LANE_A;
        end else if (load) begin
            if (any) begin
                state    <= FULL;
                out_data <= win_data;
                out_sel  <= gnt_idx;
                ptr      <= gnt_idx + 2'd1;
            end else begin
                state <= EMPTY;
            end
        end
    end

`ifdef RR_MUX4_STATS_EN
    logic [CNT_W-1:0] cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant && gnt_onehot[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux4.sv
// Directed bench for rr_mux4; grant-counter checks are compiled in with RR_MUX4_STATS_EN.
module tb_rr_mux4;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
`ifdef RR_MUX4_STATS_EN
    logic [63:0]         grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_sel [8];
    logic [7:0]  exp_dat [8];

    rr_mux4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_MUX4_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_sel",   64'(out_sel),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
`ifdef RR_MUX4_STATS_EN
        chk("rst_grant_cnt", grant_cnt, 64'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b0101;
        out_ready = 1'b1;
        #1;
        chk("ac_ready0", 64'(in_ready), 64'b0001);
        tick();
        chk("ac_valid0", 64'(out_valid), 64'd1);
        chk("ac_sel0",   64'(out_sel),   64'b00);
        chk("ac_data0",  64'(out_data),  64'hAA);
        chk("ac_ready1", 64'(in_ready),  64'b0100);
        tick();
        chk("ac_sel1",   64'(out_sel),   64'b10);
        chk("ac_data1",  64'(out_data),  64'hCC);
        chk("ac_ready2", 64'(in_ready),  64'b0001);
        tick();
        chk("ac_sel2",   64'(out_sel),   64'b00);

        // Grant lane d once so the pointer wraps back to lane a.
        in_valid = 4'b1000;
        tick();
        chk("wrap_sel",  64'(out_sel),   64'b11);
        chk("wrap_data", 64'(out_data),  64'hDD);

        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        exp_dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("rr_sel%0d", k),   64'(out_sel),   64'(exp_sel[k]));
            chk($sformatf("rr_data%0d", k),  64'(out_data),  64'(exp_dat[k]));
        end

        in_valid = 4'b0000;
        #1;
        chk("drain_ready", 64'(in_ready), 64'd0);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_sel",   64'(out_sel),   64'b11);
        chk("drain_data",  64'(out_data),  64'hDD);

        in_data   = {8'hDD, 8'hCC, 8'hA5, 8'hAA};
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        chk("hold_load_sel",  64'(out_sel),  64'b01);
        chk("hold_load_data", 64'(out_data), 64'hA5);
        in_valid = 4'hF;
        in_data  = {8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_ready%0d", k), 64'(in_ready),  64'd0);
            tick();
            chk($sformatf("hold_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold_data%0d", k),  64'(out_data),  64'hA5);
            chk($sformatf("hold_sel%0d", k),   64'(out_sel),   64'b01);
        end

        // Pointer now sits at lane c; reset must drop the held word without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd0);
`ifdef RR_MUX4_STATS_EN
        chk("mid_rst_cnt",   grant_cnt,      64'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'b0001);
        tick();
        chk("post_rst_sel",  64'(out_sel),  64'b00);
        chk("post_rst_data", 64'(out_data), 64'hAA);

`ifdef RR_MUX4_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b1000;
        repeat (65537) @(posedge clk);
        #1;
        chk("cnt_d_sat", 64'(grant_cnt[48 +: 16]), 64'hFFFF);
        chk("cnt_abc",   64'(grant_cnt[0 +: 48]),  64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
